// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state type, RS codes and default parameters for the LCD SPI streamer
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCL_LO,
        SCL_HI,
        CS_GAP
    } lcd_state_e;

    localparam logic RS_INDEX = 1'b0;
    localparam logic RS_DATA  = 1'b1;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CLK_DIV    = 2;
    localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/lcd_sync_fifo.sv
// rtl/lcd_sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module lcd_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full     = (level_q == (AW+1)'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_q];

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        do_push = push && !full;
        do_pop  = pop && !empty;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        // Simultaneous push and pop leave the occupancy unchanged.
        if (do_push && !do_pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/lcd_spi_streamer.sv
// rtl/lcd_spi_streamer.sv - FIFO-fed SPI word streamer driving an LCD controller's serial pins
module lcd_spi_streamer
    import lcd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_rs,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy,
    output logic                        done,
    output logic                        rst_lcd,
    output logic                        scl_lcd,
    output logic                        sda_lcd,
    output logic                        cs_lcd,
    output logic                        rs_lcd,
    output logic                        led_lcd
);
    localparam int BW  = $clog2(DATA_WIDTH + 1);
    localparam int DVW = $clog2(CLK_DIV + 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(CLK_DIV - 1);

    lcd_state_e            state_q, state_d;
    logic [DVW-1:0]        div_q, div_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  cs_q, cs_d, scl_q, scl_d, sda_q, sda_d;
    logic                  rs_q, rs_d, done_q, done_d;
    logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [DATA_WIDTH:0]   fifo_head;
    logic                  start_word, div_last;

    assign in_ready  = ~rst & ~fifo_full;
    assign fifo_push = in_valid & in_ready;

    lcd_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({in_rs, in_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        cs_d       = cs_q;
        scl_d      = scl_q;
        sda_d      = sda_q;
        rs_d       = rs_q;
        done_d     = 1'b0;
        fifo_pop   = 1'b0;
        start_word = 1'b0;
        div_last   = (div_q == DIV_LAST);
        case (state_q)
            IDLE: begin
                start_word = !fifo_empty;
            end
            LOAD: begin
                if (div_last) begin
                    state_d = SCL_LO;
                    div_d   = '0;
                    bit_d   = '0;
                    scl_d   = 1'b0;
                    sda_d   = shreg_q[DATA_WIDTH-1];
                end else begin
                    div_d = div_q + DVW'(1);
                end
            end
            SCL_LO: begin
                if (div_last) begin
                    state_d = SCL_HI;
                    div_d   = '0;
                    scl_d   = 1'b1;
                end else begin
                    div_d = div_q + DVW'(1);
                end
            end
            SCL_HI: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        done_d = 1'b1;
                        bit_d  = '0;
                        // A queued word keeps cs low and starts straight away.
                        if (!fifo_empty) begin
                            start_word = 1'b1;
                        end else begin
                            state_d = CS_GAP;
                            cs_d    = 1'b1;
                            scl_d   = 1'b1;
                        end
                    end else begin
                        state_d = SCL_LO;
                        bit_d   = bit_q + BW'(1);
                        shreg_d = shreg_q << 1;
                        sda_d   = shreg_q[DATA_WIDTH-2];
                        scl_d   = 1'b0;
                    end
                end else begin
                    div_d = div_q + DVW'(1);
                end
            end
            CS_GAP: begin
                if (div_last) begin
                    state_d = IDLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DVW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = '0;
            end
        endcase
        if (start_word) begin
            fifo_pop = 1'b1;
            state_d  = LOAD;
            div_d    = '0;
            shreg_d  = fifo_head[DATA_WIDTH-1:0];
            rs_d     = fifo_head[DATA_WIDTH];
            sda_d    = fifo_head[DATA_WIDTH-1];
            cs_d     = 1'b0;
            scl_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            cs_q    <= 1'b1;
            scl_q   <= 1'b1;
            sda_q   <= 1'b0;
            rs_q    <= RS_INDEX;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            cs_q    <= cs_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            rs_q    <= rs_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign cs_lcd  = cs_q;
    assign scl_lcd = scl_q;
    assign sda_lcd = sda_q;
    assign rs_lcd  = rs_q;
    assign rst_lcd = ~rst;
    assign led_lcd = 1'b1;

endmodule

// File: tb/tb_lcd_spi_streamer.sv
// tb/tb_lcd_spi_streamer.sv - directed self-checking bench for lcd_spi_streamer
module tb_lcd_spi_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_rs, in_ready;
    logic [7:0] in_data;
    logic [2:0] fifo_level;
    logic       busy, done, rst_lcd, scl_lcd, sda_lcd, cs_lcd, rs_lcd, led_lcd;

    logic        w_valid, w_rs, w_ready;
    logic [15:0] w_data;
    logic [2:0]  w_level;
    logic        w_busy, w_done, w_rst_lcd, w_scl, w_sda, w_cs, w_rs_lcd, w_led;

    lcd_spi_streamer #(.DATA_WIDTH(8), .CLK_DIV(2), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rs(in_rs),
        .in_data(in_data), .fifo_level(fifo_level), .busy(busy), .done(done),
        .rst_lcd(rst_lcd), .scl_lcd(scl_lcd), .sda_lcd(sda_lcd), .cs_lcd(cs_lcd),
        .rs_lcd(rs_lcd), .led_lcd(led_lcd)
    );

    lcd_spi_streamer #(.DATA_WIDTH(16), .CLK_DIV(1), .FIFO_DEPTH(4)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(w_ready), .in_rs(w_rs),
        .in_data(w_data), .fifo_level(w_level), .busy(w_busy), .done(w_done),
        .rst_lcd(w_rst_lcd), .scl_lcd(w_scl), .sda_lcd(w_sda), .cs_lcd(w_cs),
        .rs_lcd(w_rs_lcd), .led_lcd(w_led)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitors: bits and rs sampled on each rising SCL edge while cs is low.
    logic [63:0] cap = '0, rs_cap = '0, w_cap = '0, w_rs_cap = '0;
    int nbits = 0, ndone = 0, fall_cyc = 0, w_nbits = 0, w_ndone = 0, w_fall_cyc = 0;
    int done_at [64];
    int w_done_at = 0;
    logic scl_prev = 1'b1, cs_prev = 1'b1, w_scl_prev = 1'b1, w_cs_prev = 1'b1;

    always @(negedge clk) begin
        if (scl_lcd && !scl_prev && !cs_lcd) begin
            cap    <= {cap[62:0], sda_lcd};
            rs_cap <= {rs_cap[62:0], rs_lcd};
            nbits  <= nbits + 1;
        end
        if (!cs_lcd && cs_prev) fall_cyc <= cyc;
        if (done === 1'b1) begin
            if (ndone < 64) done_at[ndone] <= cyc;
            ndone <= ndone + 1;
        end
        scl_prev <= scl_lcd;
        cs_prev  <= cs_lcd;
    end

    always @(negedge clk) begin
        if (w_scl && !w_scl_prev && !w_cs) begin
            w_cap    <= {w_cap[62:0], w_sda};
            w_rs_cap <= {w_rs_cap[62:0], w_rs_lcd};
            w_nbits  <= w_nbits + 1;
        end
        if (!w_cs && w_cs_prev) w_fall_cyc <= cyc;
        if (w_done === 1'b1) begin
            w_done_at <= cyc;
            w_ndone   <= w_ndone + 1;
        end
        w_scl_prev <= w_scl;
        w_cs_prev  <= w_cs;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic rs, input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_rs    = rs;
        in_data  = d;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("push_accepted", 64'(n < 200), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int bound, input string tag);
        int n;
        n = 0;
        while (ndone < target && n < bound) begin
            tick();
            n++;
        end
        chk(tag, 64'(ndone >= target), 64'd1);
    endtask

    int base_bits, base_done, gaps, n;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_rs = 1'b0; in_data = '0;
        w_valid = 1'b0; w_rs = 1'b0; w_data = '0;
        tick(); tick(); tick();

        // Reset state
        chk("rst_cs", 64'(cs_lcd), 64'd1);
        chk("rst_scl", 64'(scl_lcd), 64'd1);
        chk("rst_sda", 64'(sda_lcd), 64'd0);
        chk("rst_rs", 64'(rs_lcd), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_rst_lcd", 64'(rst_lcd), 64'd0);
        chk("rst_led", 64'(led_lcd), 64'd1);
        rst = 1'b0;
        tick();
        chk("run_in_ready", 64'(in_ready), 64'd1);
        chk("run_rst_lcd", 64'(rst_lcd), 64'd1);

        // Single index word 0xA5
        base_bits = nbits;
        push(1'b0, 8'hA5);
        chk("a5_level_after_push", 64'(fifo_level), 64'd1);
        chk("a5_cs_still_high", 64'(cs_lcd), 64'd1);
        tick();
        chk("a5_cs_low_2clk", 64'(cs_lcd), 64'd0);
        chk("a5_busy", 64'(busy), 64'd1);
        chk("a5_level_popped", 64'(fifo_level), 64'd0);
        chk("a5_sda_msb", 64'(sda_lcd), 64'd1);
        wait_done(1, 100, "a5_done_seen");
        chk("a5_bits", cap[7:0], 64'hA5);
        chk("a5_nbits", 64'(nbits - base_bits), 64'd8);
        chk("a5_rs_index", rs_cap[7:0], 64'h00);
        chk("a5_word_time", 64'(done_at[0] - fall_cyc), 64'd34);
        chk("a5_cs_high_at_done", 64'(cs_lcd), 64'd1);
        tick();
        chk("a5_done_one_cycle", 64'(done), 64'd0);
        chk("a5_gap_busy", 64'(busy), 64'd1);
        tick();
        chk("a5_idle_after_gap", 64'(busy), 64'd0);
        chk("a5_total_done", 64'(ndone), 64'd1);

        // Burst of three data words
        base_bits = nbits;
        base_done = ndone;
        push(1'b1, 8'h11);
        push(1'b1, 8'h22);
        push(1'b1, 8'h33);
        gaps = 0;
        n = 0;
        while (ndone < base_done + 3 && n < 300) begin
            tick();
            n++;
            if (cs_lcd && ndone < base_done + 3) gaps++;
        end
        chk("burst_done_seen", 64'(ndone), 64'(base_done + 3));
        chk("burst_cs_continuous", 64'(gaps), 64'd0);
        chk("burst_bits", cap[23:0], 64'h112233);
        chk("burst_nbits", 64'(nbits - base_bits), 64'd24);
        chk("burst_rs_data", rs_cap[23:0], 64'hFFFFFF);
        chk("burst_spacing_1", 64'(done_at[base_done + 1] - done_at[base_done]), 64'd34);
        chk("burst_spacing_2", 64'(done_at[base_done + 2] - done_at[base_done + 1]), 64'd34);
        tick(); tick(); tick();
        chk("burst_idle", 64'(busy), 64'd0);

        // FIFO fills while a transfer is in progress
        base_bits = nbits;
        base_done = ndone;
        push(1'b0, 8'hC3);
        push(1'b0, 8'h01);
        push(1'b0, 8'h02);
        push(1'b0, 8'h03);
        push(1'b0, 8'h04);
        chk("full_level", 64'(fifo_level), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_data  = 8'h05;
        tick();
        chk("full_held_level", 64'(fifo_level), 64'd4);
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("full_ready_returns", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        wait_done(base_done + 6, 400, "full_done_seen");
        chk("full_order", cap[47:0], 64'h0000_C301_0203_0405);
        chk("full_nbits", 64'(nbits - base_bits), 64'd48);
        tick(); tick(); tick();

        // Reset in the middle of word 0xFF
        base_bits = nbits;
        base_done = ndone;
        push(1'b1, 8'hFF);
        n = 0;
        while (nbits < base_bits + 4 && n < 100) begin
            tick();
            n++;
        end
        chk("abort_reached_bit4", 64'(nbits - base_bits), 64'd4);
        rst = 1'b1;
        tick();
        chk("abort_cs_high", 64'(cs_lcd), 64'd1);
        chk("abort_level", 64'(fifo_level), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        tick();
        chk("abort_no_done", 64'(ndone), 64'(base_done));
        base_bits = nbits;
        push(1'b0, 8'h0F);
        wait_done(base_done + 1, 100, "after_abort_done_seen");
        chk("after_abort_bits", cap[7:0], 64'h0F);
        chk("after_abort_nbits", 64'(nbits - base_bits), 64'd8);
        tick(); tick(); tick();

        // 16-bit words at CLK_DIV=1
        w_valid = 1'b1;
        w_rs    = 1'b1;
        w_data  = 16'h8001;
        chk("w16_ready", 64'(w_ready), 64'd1);
        tick();
        w_valid = 1'b0;
        n = 0;
        while (w_ndone < 1 && n < 100) begin
            tick();
            n++;
        end
        chk("w16_done_seen", 64'(w_ndone), 64'd1);
        chk("w16_nbits", 64'(w_nbits), 64'd16);
        chk("w16_bits", w_cap[15:0], 64'h8001);
        chk("w16_first_bit", 64'(w_cap[15]), 64'd1);
        chk("w16_last_bit", 64'(w_cap[0]), 64'd1);
        chk("w16_rs_data", w_rs_cap[15:0], 64'hFFFF);
        chk("w16_word_time", 64'(w_done_at - w_fall_cyc), 64'd33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
